// File: rtl/mem_fill_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_fill_arbiter_if
//
// Bundles every handshake and bus signal of mem_fill_arbiter. The clock and
// the reset stay plain ports on the arbiter.
//
//   Requesters : i_req, i_addr          I-cache block fill request
//                d_req, d_wr, d_addr,   D-cache fill (d_wr=0) or
//                d_wdata                single-word write (d_wr=1)
//   Memory     : mem_en, mem_wr, mem_addr, mem_wdata   request channel
//                mem_rdata, mem_valid                  pipelined read return
//   Fill out   : fill_data, fill_idx, i_fill_we, d_fill_we
//   Status     : i_done, d_done, busy
//
// Modports:
//   slave  - the arbiter's view (drives memory requests, fill strobes, status)
//   master - the environment's view (cache controllers plus memory model)
// -----------------------------------------------------------------------------
interface mem_fill_arbiter_if #(
    parameter int IDX_W = 2
) ();
    logic             i_req;
    logic [15:0]      i_addr;
    logic             d_req;
    logic             d_wr;
    logic [15:0]      d_addr;
    logic [15:0]      d_wdata;

    logic             mem_en;
    logic             mem_wr;
    logic [15:0]      mem_addr;
    logic [15:0]      mem_wdata;
    logic [15:0]      mem_rdata;
    logic             mem_valid;

    logic [15:0]      fill_data;
    logic [IDX_W-1:0] fill_idx;
    logic             i_fill_we;
    logic             d_fill_we;
    logic             i_done;
    logic             d_done;
    logic             busy;

    modport slave (
        input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata,
        input  mem_rdata, mem_valid,
        output mem_en, mem_wr, mem_addr, mem_wdata,
        output fill_data, fill_idx, i_fill_we, d_fill_we,
        output i_done, d_done, busy
    );

    modport master (
        output i_req, i_addr, d_req, d_wr, d_addr, d_wdata,
        output mem_rdata, mem_valid,
        input  mem_en, mem_wr, mem_addr, mem_wdata,
        input  fill_data, fill_idx, i_fill_we, d_fill_we,
        input  i_done, d_done, busy
    );
endinterface

// File: rtl/mem_fill_arbiter.sv
// -----------------------------------------------------------------------------
// mem_fill_arbiter
//
// Shares one pipelined memory port between the I-cache fill path and the
// D-cache, which issues either a block fill or a single-word write-through.
// A block fill streams BURST consecutive word reads, one per cycle. Read
// returns may overlap the issue phase. Each return is steered into the
// owning cache line at fill_idx. A one-cycle done pulse ends every operation.
//
// Ports:
//   clk  - clock; all state changes on the rising edge
//   rst  - asynchronous active-high reset
//   bus  - mem_fill_arbiter_if.slave: requester, memory, fill and status
//          signals (see the interface file for the list)
//
// Parameters:
//   BURST - words per block fill (power of two, 2..8)
//   IDX_W - log2(BURST), width of fill_idx and of the internal counters
// -----------------------------------------------------------------------------
module mem_fill_arbiter #(
    parameter int BURST = 4,
    parameter int IDX_W = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_fill_arbiter_if.slave    bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        DRAIN = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_e;

    localparam logic             SIDE_I     = 1'b0;
    localparam logic             SIDE_D     = 1'b1;
    // Byte-address mask that clears the in-block offset (2 bytes per word).
    localparam logic [15:0]      BLOCK_MASK = ~(16'(2 * BURST - 1));
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(BURST - 1);

    state_e           state_reg, state_next;
    logic             owner_reg, owner_next;
    logic             last_grant_reg, last_grant_next;
    logic [15:0]      base_reg, base_next;
    logic [15:0]      wdata_reg, wdata_next;
    logic [IDX_W-1:0] issue_cnt_reg, issue_cnt_next;
    logic [IDX_W-1:0] ret_cnt_reg, ret_cnt_next;

    logic             grant_valid;
    logic             grant_side;
    logic             ret_fire;
    logic             last_ret;
    logic             mem_en;
    logic             mem_wr;
    logic [15:0]      mem_addr;
    logic [15:0]      mem_wdata;
    logic [1:0]       fill_we_vec;
    logic [1:0]       done_vec;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            owner_reg      <= SIDE_I;
            last_grant_reg <= SIDE_I;
            base_reg       <= 16'h0000;
            wdata_reg      <= 16'h0000;
            issue_cnt_reg  <= '0;
            ret_cnt_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            last_grant_reg <= last_grant_next;
            base_reg       <= base_next;
            wdata_reg      <= wdata_next;
            issue_cnt_reg  <= issue_cnt_next;
            ret_cnt_reg    <= ret_cnt_next;
        end
    end

    // Next-state and memory-request logic
    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        last_grant_next = last_grant_reg;
        base_next       = base_reg;
        wdata_next      = wdata_reg;
        issue_cnt_next  = issue_cnt_reg;
        ret_cnt_next    = ret_cnt_reg;
        mem_en          = 1'b0;
        mem_wr          = 1'b0;
        mem_addr        = 16'h0000;
        mem_wdata       = 16'h0000;

        // On a tie, the side that was not granted last time wins. The reset
        // value of last_grant (I) therefore hands the first tie to D.
        grant_valid = bus.i_req | bus.d_req;
        if (bus.i_req && bus.d_req) begin
            grant_side = ~last_grant_reg;
        end else begin
            grant_side = bus.d_req ? SIDE_D : SIDE_I;
        end

        // Read returns count only while a fill is in flight. A stray
        // mem_valid in any other state must not move the counters.
        ret_fire = bus.mem_valid && ((state_reg == ISSUE) || (state_reg == DRAIN));
        last_ret = ret_fire && (ret_cnt_reg == LAST_IDX);

        unique case (state_reg)
            IDLE: begin
                if (grant_valid) begin
                    owner_next      = grant_side;
                    last_grant_next = grant_side;
                    issue_cnt_next  = '0;
                    ret_cnt_next    = '0;
                    if ((grant_side == SIDE_D) && bus.d_wr) begin
                        state_next = WRITE;
                        base_next  = bus.d_addr;
                        wdata_next = bus.d_wdata;
                    end else begin
                        state_next = ISSUE;
                        base_next  = ((grant_side == SIDE_D) ? bus.d_addr : bus.i_addr)
                                     & BLOCK_MASK;
                    end
                end
            end
            ISSUE: begin
                mem_en         = 1'b1;
                mem_addr       = base_reg + 16'({issue_cnt_reg, 1'b0});
                issue_cnt_next = issue_cnt_reg + IDX_W'(1);
                if (last_ret) begin
                    state_next = DONE;
                end else if (issue_cnt_reg == LAST_IDX) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (last_ret) begin
                    state_next = DONE;
                end
            end
            WRITE: begin
                mem_en     = 1'b1;
                mem_wr     = 1'b1;
                mem_addr   = base_reg;
                mem_wdata  = wdata_reg;
                state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (ret_fire) begin
            ret_cnt_next = ret_cnt_reg + IDX_W'(1);
        end
    end

    // Per-requester fill write enables and done pulses. Index 0 is I, index 1 is D.
    for (genvar gi = 0; gi < 2; gi++) begin : g_side
        localparam logic SIDE = (gi == 1);
        assign fill_we_vec[gi] = ret_fire && (owner_reg == SIDE);
        assign done_vec[gi]    = (state_reg == DONE) && (owner_reg == SIDE);
    end

    assign bus.mem_en    = mem_en;
    assign bus.mem_wr    = mem_wr;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.fill_data = bus.mem_rdata;
    assign bus.fill_idx  = ret_cnt_reg;
    assign bus.i_fill_we = fill_we_vec[0];
    assign bus.d_fill_we = fill_we_vec[1];
    assign bus.i_done    = done_vec[0];
    assign bus.d_done    = done_vec[1];
    assign bus.busy      = (state_reg != IDLE);

endmodule
